// File: rtl/palette_pkg.sv
// Shared constants, entry layout and FSM state type for the palette command generator.
package palette_pkg;

    localparam logic [4:0]  OP_WRITE      = 5'b10011;
    localparam logic [4:0]  OP_HOLD       = 5'b11000;
    localparam logic [4:0]  OP_CLEAR      = 5'b00000;
    localparam logic        HALF_RG       = 1'b0;
    localparam logic        HALF_BX       = 1'b1;
    localparam logic [15:0] CMD_IDLE_WORD = 16'hC000;
    localparam int          ENTRY_W       = 28;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RG,
        ST_BX,
        ST_CLR
    } palState_t;

    typedef struct packed {
        logic [3:0]  slot;
        logic [23:0] rgb;
    } palEntry_t;

    function automatic logic [15:0] packCmd(input logic [4:0] op, input logic [3:0] slot,
                                            input logic half);
        return {op, slot, half, 6'b000000};
    endfunction

endpackage

// File: rtl/palette_entry_fifo.sv
// Synchronous first-word-fall-through FIFO holding pending palette entries.
module palette_entry_fifo
    import palette_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = ENTRY_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wrEn,
    input  logic [WIDTH-1:0] wrData,
    input  logic             rdEn,
    output logic [WIDTH-1:0] rdData,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wrPtr;
    logic [AW:0]      rdPtr;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty  = (wrPtr == rdPtr);
    assign full   = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
    assign rdData = mem[rdPtr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            if (wrEn && !full) begin
                wrPtr <= wrPtr + (AW+1)'(1);
            end
            if (rdEn && !empty) begin
                rdPtr <= rdPtr + (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wrEn && !full) begin
            mem[wrPtr[AW-1:0]] <= wrData;
        end
    end

endmodule

// File: rtl/palette_cmd_gen.sv
// Serialises palette entries into RG/BX write beats and inserts CLEAR commands on request.
// Optional build macro PALETTE_CMD_FIFO_EN: buffer entries in a FIFO_DEPTH-deep FIFO.
module palette_cmd_gen
    import palette_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_valid,
    output logic        load_ready,
    input  logic [3:0]  load_slot,
    input  logic [23:0] load_rgb,
    input  logic        clr_req,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [15:0] command,
    output logic [15:0] cmd_data
);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : gBadDepth
        $error("FIFO_DEPTH must be a power of two >= 2");
    end

    palEntry_t pushEntry;
    palEntry_t headEntry;
    logic      bufValid;
    logic      bufFull;
    logic      push;
    logic      pop;

    assign pushEntry  = palEntry_t'({load_slot, load_rgb});
    assign load_ready = !rst && !bufFull;
    assign push       = load_valid && load_ready;

`ifdef PALETTE_CMD_FIFO_EN
    logic               fifoEmpty;
    logic [ENTRY_W-1:0] fifoRdData;

    palette_entry_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) uEntryFifo (
        .clk    (clk),
        .rst    (rst),
        .wrEn   (push),
        .wrData (pushEntry),
        .rdEn   (pop),
        .rdData (fifoRdData),
        .empty  (fifoEmpty),
        .full   (bufFull)
    );

    assign headEntry = palEntry_t'(fifoRdData);
    assign bufValid  = !fifoEmpty;
`else
    palEntry_t holdReg;
    logic      holdValid;

    // Push only happens when empty and pop only when full, so they never collide.
    always_ff @(posedge clk) begin
        if (rst) begin
            holdValid <= 1'b0;
        end else if (push) begin
            holdValid <= 1'b1;
        end else if (pop) begin
            holdValid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            holdReg <= pushEntry;
        end
    end

    assign headEntry = holdReg;
    assign bufValid  = holdValid;
    assign bufFull   = holdValid;
`endif

    palState_t   state;
    palState_t   stateNext;
    logic        cmdValidReg;
    logic        validNext;
    logic [15:0] cmdWordReg;
    logic [15:0] cmdNext;
    logic [15:0] cmdDataReg;
    logic [15:0] dataNext;
    logic        clrPend;
    logic        clrAck;
    logic        dispatch;
    logic        pendEff;
    logic [3:0]  curSlot;
    logic [7:0]  curBlue;

    always_comb begin
        stateNext = state;
        validNext = cmdValidReg;
        cmdNext   = cmdWordReg;
        dataNext  = cmdDataReg;
        pop       = 1'b0;
        clrAck    = 1'b0;
        dispatch  = 1'b0;
        pendEff   = clrPend;

        case (state)
            ST_IDLE: dispatch = 1'b1;
            ST_RG: begin
                if (cmd_ready) begin
                    stateNext = ST_BX;
                    cmdNext   = packCmd(OP_WRITE, curSlot, HALF_BX);
                    dataNext  = {curBlue, 8'h00};
                end
            end
            ST_BX: dispatch = cmd_ready;
            ST_CLR: begin
                if (cmd_ready) begin
                    dispatch = 1'b1;
                    clrAck   = 1'b1;
                    pendEff  = 1'b0;
                end
            end
            default: stateNext = ST_IDLE;
        endcase

        // Choosing the next command right at the accepting edge keeps back-to-back
        // entries at two cycles each; a pending clear always wins over entries.
        if (dispatch) begin
            if (pendEff) begin
                stateNext = ST_CLR;
                validNext = 1'b1;
                cmdNext   = packCmd(OP_CLEAR, 4'd0, HALF_RG);
                dataNext  = 16'h0000;
            end else if (bufValid) begin
                pop       = 1'b1;
                stateNext = ST_RG;
                validNext = 1'b1;
                cmdNext   = packCmd(OP_WRITE, headEntry.slot, HALF_RG);
                dataNext  = headEntry.rgb[23:8];
            end else begin
                stateNext = ST_IDLE;
                validNext = 1'b0;
                cmdNext   = CMD_IDLE_WORD;
                dataNext  = 16'h0000;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            cmdValidReg <= 1'b0;
            cmdWordReg  <= CMD_IDLE_WORD;
            cmdDataReg  <= 16'h0000;
            clrPend     <= 1'b0;
        end else begin
            state       <= stateNext;
            cmdValidReg <= validNext;
            cmdWordReg  <= cmdNext;
            cmdDataReg  <= dataNext;
            clrPend     <= clr_req || (clrPend && !clrAck);
        end
    end

    // Slot and blue byte of the entry in flight, needed later for its BX beat.
    always_ff @(posedge clk) begin
        if (pop) begin
            curSlot <= headEntry.slot;
            curBlue <= headEntry.rgb[7:0];
        end
    end

    assign cmd_valid = cmdValidReg;
    assign command   = cmdWordReg;
    assign cmd_data  = cmdDataReg;

endmodule

// File: tb/tb_palette_cmd_gen.sv
// Self-checking bench for palette_cmd_gen: directed scenarios plus a randomized stream.
module tb_palette_cmd_gen;

    localparam int DEPTH = 4;
`ifdef PALETTE_CMD_FIFO_EN
    localparam int CAP = DEPTH + 1;
`else
    localparam int CAP = 2;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_valid = 1'b0;
    logic        load_ready;
    logic [3:0]  load_slot = '0;
    logic [23:0] load_rgb = '0;
    logic        clr_req = 1'b0;
    logic        cmd_valid;
    logic        cmd_ready = 1'b0;
    logic [15:0] command;
    logic [15:0] cmd_data;

    int checks = 0;
    int errors = 0;
    logic [31:0] seenQ[$];

    always #5 clk = ~clk;

    palette_cmd_gen #(.FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_slot  (load_slot),
        .load_rgb   (load_rgb),
        .clr_req    (clr_req),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .command    (command),
        .cmd_data   (cmd_data)
    );

    // Record every accepted beat as {command, cmd_data}.
    always @(negedge clk) begin
        if (!rst && cmd_valid && cmd_ready) seenQ.push_back({command, cmd_data});
    end

    function automatic logic [31:0] rgBeat(input logic [3:0] s, input logic [23:0] c);
        return {5'b10011, s, 1'b0, 6'b000000, c[23:8]};
    endfunction

    function automatic logic [31:0] bxBeat(input logic [3:0] s, input logic [23:0] c);
        return {5'b10011, s, 1'b1, 6'b000000, c[7:0], 8'h00};
    endfunction

    task automatic idleCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called at a drive point (just after a rising edge); returns at the next one.
    task automatic offerEntry(input logic [3:0] s, input logic [23:0] c, output bit ok);
        ok = 1'b0;
        load_valid = 1'b1;
        load_slot = s;
        load_rgb = c;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (load_ready) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        load_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cmd_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (cmd_valid !== 1'b0 || command !== 16'hC000 || cmd_data !== 16'h0000) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%b cmd=%h data=%h expected valid=0 cmd=c000 data=0000",
                     cmd_valid, command, cmd_data);
        end
        checks++;
        if (load_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_load_ready: got %b expected 0", load_ready);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (load_ready !== 1'b1 || cmd_valid !== 1'b0) begin
            errors++;
            $display("FAIL after_reset: got ready=%b valid=%b expected ready=1 valid=0", load_ready, cmd_valid);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_write();
        bit ok;
        seenQ.delete();
        cmd_ready = 1'b1;
        offerEntry(4'd5, 24'h123456, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL single_accept: got no accept expected accept"); end
        @(negedge clk);
        checks++;
        if (cmd_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_latency_early: got valid=%b expected 0", cmd_valid);
        end
        @(negedge clk);
        checks++;
        if (cmd_valid !== 1'b1 || command !== 16'h9A80 || cmd_data !== 16'h1234) begin
            errors++;
            $display("FAIL single_latency_rg: got valid=%b cmd=%h data=%h expected 1 9a80 1234",
                     cmd_valid, command, cmd_data);
        end
        @(posedge clk);
        #1;
        idleCycles(4);
        checks++;
        if (seenQ.size() != 2) begin
            errors++;
            $display("FAIL single_beats: got %0d beats expected 2", seenQ.size());
        end else begin
            checks++;
            if (seenQ[0] !== 32'h9A80_1234 || seenQ[1] !== 32'h9AC0_5600) begin
                errors++;
                $display("FAIL single_words: got %h %h expected 9a801234 9ac05600", seenQ[0], seenQ[1]);
            end
        end
        @(negedge clk);
        checks++;
        if (cmd_valid !== 1'b0 || command !== 16'hC000 || cmd_data !== 16'h0000) begin
            errors++;
            $display("FAIL single_idle: got valid=%b cmd=%h data=%h expected 0 c000 0000",
                     cmd_valid, command, cmd_data);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_backpressure();
        bit ok;
        seenQ.delete();
        cmd_ready = 1'b0;
        offerEntry(4'd15, 24'hFFEEDD, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL bp_accept: got no accept expected accept"); end
        idleCycles(1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (cmd_valid !== 1'b1 || command !== 16'h9F80 || cmd_data !== 16'hFFEE) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got valid=%b cmd=%h data=%h expected 1 9f80 ffee",
                         k, cmd_valid, command, cmd_data);
            end
            @(posedge clk);
            #1;
        end
        cmd_ready = 1'b1;
        idleCycles(5);
        checks++;
        if (seenQ.size() != 2) begin
            errors++;
            $display("FAIL bp_beats: got %0d beats expected 2", seenQ.size());
        end else begin
            checks++;
            if (seenQ[0] !== 32'h9F80_FFEE || seenQ[1] !== 32'h9FC0_DD00) begin
                errors++;
                $display("FAIL bp_words: got %h %h expected 9f80ffee 9fc0dd00", seenQ[0], seenQ[1]);
            end
        end
    endtask

    task automatic test_clear();
        bit ok;
        logic [3:0]  s;
        logic [23:0] c1;
        logic [23:0] c2;
        logic [31:0] exp5[5];

        // Clear and entry arriving together from idle: the clear goes first.
        seenQ.delete();
        cmd_ready = 1'b1;
        s = 4'($urandom);
        c1 = 24'($urandom);
        clr_req = 1'b1;
        load_valid = 1'b1;
        load_slot = s;
        load_rgb = c1;
        @(negedge clk);
        checks++;
        if (load_ready !== 1'b1) begin
            errors++;
            $display("FAIL clr_idle_ready: got %b expected 1", load_ready);
        end
        @(posedge clk);
        #1;
        clr_req = 1'b0;
        load_valid = 1'b0;
        idleCycles(6);
        checks++;
        if (seenQ.size() != 3) begin
            errors++;
            $display("FAIL clr_idle_beats: got %0d beats expected 3", seenQ.size());
        end else begin
            checks++;
            if (seenQ[0] !== 32'h0 || seenQ[1] !== rgBeat(s, c1) || seenQ[2] !== bxBeat(s, c1)) begin
                errors++;
                $display("FAIL clr_idle_order: got %h %h %h expected %h %h %h",
                         seenQ[0], seenQ[1], seenQ[2], 32'h0, rgBeat(s, c1), bxBeat(s, c1));
            end
        end

        // Two clear pulses during the RG beat of slot 2 with a second entry waiting.
        seenQ.delete();
        cmd_ready = 1'b0;
        c1 = 24'($urandom);
        c2 = 24'($urandom);
        offerEntry(4'd2, c1, ok);
        idleCycles(1);
        offerEntry(4'd7, c2, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL clr_second_accept: got no accept expected accept"); end
        clr_req = 1'b1;
        idleCycles(1);
        clr_req = 1'b0;
        idleCycles(1);
        clr_req = 1'b1;
        idleCycles(1);
        clr_req = 1'b0;
        cmd_ready = 1'b1;
        idleCycles(10);
        exp5[0] = rgBeat(4'd2, c1);
        exp5[1] = bxBeat(4'd2, c1);
        exp5[2] = 32'h0;
        exp5[3] = rgBeat(4'd7, c2);
        exp5[4] = bxBeat(4'd7, c2);
        checks++;
        if (seenQ.size() != 5) begin
            errors++;
            $display("FAIL clr_merge_beats: got %0d beats expected 5", seenQ.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (seenQ[i] !== exp5[i]) begin
                    errors++;
                    $display("FAIL clr_order[%0d]: got %h expected %h", i, seenQ[i], exp5[i]);
                end
            end
        end
    endtask

    task automatic test_full();
        logic [3:0]  slots[6];
        logic [23:0] rgbs[6];
        int k;
        bit acc;
        seenQ.delete();
        cmd_ready = 1'b0;
        k = 0;
        for (int i = 0; i < 6; i++) begin
            slots[i] = 4'($urandom);
            rgbs[i] = 24'($urandom);
        end
        for (int cyc = 0; cyc < 20; cyc++) begin
            load_valid = (k < 6);
            if (k < 6) begin
                load_slot = slots[k];
                load_rgb = rgbs[k];
            end
            @(negedge clk);
            acc = load_valid && load_ready;
            @(posedge clk);
            #1;
            if (acc) k++;
        end
        load_valid = 1'b0;
        checks++;
        if (k != CAP) begin
            errors++;
            $display("FAIL full_accepts: got %0d accepts expected %0d", k, CAP);
        end
        @(negedge clk);
        checks++;
        if (load_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_ready: got %b expected 0", load_ready);
        end
        @(posedge clk);
        #1;
        cmd_ready = 1'b1;
        idleCycles(4 * CAP + 6);
        checks++;
        if (seenQ.size() != 2 * k) begin
            errors++;
            $display("FAIL full_beats: got %0d beats expected %0d", seenQ.size(), 2 * k);
        end else begin
            for (int i = 0; i < k; i++) begin
                checks++;
                if (seenQ[2*i] !== rgBeat(slots[i], rgbs[i]) || seenQ[2*i+1] !== bxBeat(slots[i], rgbs[i])) begin
                    errors++;
                    $display("FAIL full_order[%0d]: got %h %h expected %h %h", i, seenQ[2*i], seenQ[2*i+1],
                             rgBeat(slots[i], rgbs[i]), bxBeat(slots[i], rgbs[i]));
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        logic [3:0]  s1;
        logic [23:0] c1;
        seenQ.delete();
        cmd_ready = 1'b0;
        s1 = 4'($urandom);
        c1 = 24'($urandom);
        offerEntry(s1, c1, ok);
        idleCycles(1);
        offerEntry(4'($urandom), 24'($urandom), ok);
        cmd_ready = 1'b1;
        idleCycles(1);
        clr_req = 1'b1;
        rst = 1'b1;
        idleCycles(1);
        clr_req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (cmd_valid !== 1'b0 || command !== 16'hC000 || load_ready !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_during: got valid=%b cmd=%h ready=%b expected 0 c000 0",
                     cmd_valid, command, load_ready);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (load_ready !== 1'b1 || cmd_valid !== 1'b0 || command !== 16'hC000 || cmd_data !== 16'h0000) begin
            errors++;
            $display("FAIL rstmid_after: got ready=%b valid=%b cmd=%h data=%h expected 1 0 c000 0000",
                     load_ready, cmd_valid, command, cmd_data);
        end
        @(posedge clk);
        #1;
        idleCycles(8);
        checks++;
        if (seenQ.size() != 1 || seenQ[0] !== rgBeat(s1, c1)) begin
            errors++;
            $display("FAIL rstmid_beats: got %0d beats first=%h expected 1 beat %h",
                     seenQ.size(), (seenQ.size() > 0) ? seenQ[0] : 32'hx, rgBeat(s1, c1));
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0]  slots[6];
        logic [23:0] rgbs[6];
        int k;
        int run;
        int maxRun;
        bit acc;
        seenQ.delete();
        cmd_ready = 1'b1;
        k = 0;
        run = 0;
        maxRun = 0;
        for (int i = 0; i < 6; i++) begin
            slots[i] = 4'($urandom);
            rgbs[i] = 24'($urandom);
        end
        for (int cyc = 0; cyc < 60; cyc++) begin
            load_valid = (k < 6);
            if (k < 6) begin
                load_slot = slots[k];
                load_rgb = rgbs[k];
            end
            @(negedge clk);
            run = cmd_valid ? run + 1 : 0;
            if (run > maxRun) maxRun = run;
            acc = load_valid && load_ready;
            @(posedge clk);
            #1;
            if (acc) k++;
        end
        load_valid = 1'b0;
        checks++;
        if (maxRun != 12) begin
            errors++;
            $display("FAIL b2b_throughput: got %0d consecutive valid cycles expected 12", maxRun);
        end
        checks++;
        if (seenQ.size() != 12) begin
            errors++;
            $display("FAIL b2b_beats: got %0d beats expected 12", seenQ.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (seenQ[2*i] !== rgBeat(slots[i], rgbs[i]) || seenQ[2*i+1] !== bxBeat(slots[i], rgbs[i])) begin
                    errors++;
                    $display("FAIL b2b_order[%0d]: got %h %h expected %h %h", i, seenQ[2*i], seenQ[2*i+1],
                             rgBeat(slots[i], rgbs[i]), bxBeat(slots[i], rgbs[i]));
                end
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] expQ[$];
        int nSent;
        bit prevStall;
        logic [15:0] prevCmd;
        logic [15:0] prevData;
        int cyc;
        localparam int TOTAL = 40;
        seenQ.delete();
        nSent = 0;
        prevStall = 1'b0;
        prevCmd = '0;
        prevData = '0;
        cyc = 0;
        while (cyc < 3000 && !(nSent == TOTAL && seenQ.size() == expQ.size())) begin
            cmd_ready = ($urandom_range(0, 3) != 0);
            load_valid = (nSent < TOTAL) && ($urandom_range(0, 1) == 1);
            load_slot = 4'($urandom);
            load_rgb = 24'($urandom);
            @(negedge clk);
            if (prevStall) begin
                checks++;
                if (cmd_valid !== 1'b1 || command !== prevCmd || cmd_data !== prevData) begin
                    errors++;
                    $display("FAIL rand_stable: got valid=%b cmd=%h data=%h expected 1 %h %h",
                             cmd_valid, command, cmd_data, prevCmd, prevData);
                end
            end
            if (!cmd_valid) begin
                checks++;
                if (command !== 16'hC000 || cmd_data !== 16'h0000) begin
                    errors++;
                    $display("FAIL rand_idle: got cmd=%h data=%h expected c000 0000", command, cmd_data);
                end
            end
            prevStall = cmd_valid && !cmd_ready;
            prevCmd = command;
            prevData = cmd_data;
            if (load_valid && load_ready) begin
                expQ.push_back(rgBeat(load_slot, load_rgb));
                expQ.push_back(bxBeat(load_slot, load_rgb));
                nSent++;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        load_valid = 1'b0;
        checks++;
        if (nSent != TOTAL || seenQ.size() != expQ.size()) begin
            errors++;
            $display("FAIL rand_done: got sent=%0d beats=%0d expected sent=%0d beats=%0d",
                     nSent, seenQ.size(), TOTAL, expQ.size());
        end else begin
            for (int i = 0; i < expQ.size(); i++) begin
                checks++;
                if (seenQ[i] !== expQ[i]) begin
                    errors++;
                    $display("FAIL rand_beat[%0d]: got %h expected %h", i, seenQ[i], expQ[i]);
                end
            end
        end
        cmd_ready = 1'b1;
        idleCycles(3);
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_backpressure();
        test_clear();
        test_full();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
